// File: rtl/div_pkg.sv
// Shared widths and FSM state encodings for the sequential unsigned divider.
package div_pkg;

    localparam int unsigned NW = 16;
    localparam int unsigned DW = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, compare, conditionally subtract.
module div_step #(
    parameter int unsigned DW = div_pkg::DW
) (
    input  logic [DW-1:0] i_part,
    input  logic          i_bit,
    input  logic [DW-1:0] i_div,
    output logic [DW-1:0] o_rem,
    output logic          o_qbit
);

    logic [DW:0]   w_shift;
    logic          w_ge;
    logic [DW-1:0] w_diff;

    // The true difference is always < divisor, so DW bits of the subtraction suffice.
    always_comb begin
        w_shift = {i_part, i_bit};
        w_ge    = (w_shift >= {1'b0, i_div});
        w_diff  = w_shift[DW-1:0] - i_div;
        o_qbit  = w_ge;
        o_rem   = w_ge ? w_diff : w_shift[DW-1:0];
    end

endmodule

// File: rtl/sequential_unsigned_div.sv
// Multi-cycle unsigned divider: NW restoring iterations per division, divide-by-zero short-cut.
module sequential_unsigned_div
    import div_pkg::*;
#(
    parameter int unsigned NW = div_pkg::NW,
    parameter int unsigned DW = div_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [NW-1:0] q,
    output logic [DW-1:0] r
);

    localparam int unsigned CW = $clog2(NW + 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_part;
    logic [NW-1:0] r_quo;
    logic [DW-1:0] r_div;
    logic [NW-1:0] r_q;
    logic [DW-1:0] r_r;
    logic          r_dz;

    logic [DW-1:0] w_rem;
    logic          w_qbit;

    // r_quo shifts dividend bits out at the top and quotient bits in at the bottom.
    div_step #(.DW(DW)) u_step (
        .i_part (r_part),
        .i_bit  (r_quo[NW-1]),
        .i_div  (r_div),
        .o_rem  (w_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_part  <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (b == '0) begin
                            r_state <= S_DONE;
                            r_q     <= '1;
                            r_r     <= '1;
                            r_dz    <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_cnt   <= CW'(NW);
                            r_dz    <= 1'b0;
                            r_part  <= '0;
                            r_quo   <= a;
                            r_div   <= b;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_part <= w_rem;
                    r_quo  <= {r_quo[NW-2:0], w_qbit};
                    r_cnt  <= r_cnt - CW'(1);
                    // Final iteration: results are taken straight from the step outputs.
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                        r_q     <= {r_quo[NW-2:0], w_qbit};
                        r_r     <= w_rem;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_CALC);
        done = (r_state == S_DONE);
        dz   = r_dz;
        q    = r_q;
        r    = r_r;
    end

endmodule
